// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: picks one of three FP result sources (load, div/sqrt,
// ALU) per cycle for the single register-file write port. It also keeps a
// per-register pending scoreboard so the issue stage can stall on hazards.
module fp_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int IDX_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [IDX_W-1:0]  ld_index,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              dv_valid,
    output logic              dv_ready,
    input  logic [IDX_W-1:0]  dv_index,
    input  logic [DATA_W-1:0] dv_data,
    input  logic              al_valid,
    output logic              al_ready,
    input  logic [IDX_W-1:0]  al_index,
    input  logic [DATA_W-1:0] al_data,
    input  logic              iss_en,
    input  logic [IDX_W-1:0]  iss_index,
    input  logic [IDX_W-1:0]  chk_rs1,
    input  logic [IDX_W-1:0]  chk_rs2,
    input  logic [IDX_W-1:0]  chk_rd,
    output logic              hazard,
    output logic              w_en,
    output logic [IDX_W-1:0]  w_index,
    output logic [DATA_W-1:0] w_data
);

    localparam int NREG  = 1 << IDX_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_reg;
    logic [CNT_W-1:0]  starve_next;
    logic              promote;
    logic              ld_gnt;
    logic              dv_gnt;
    logic              al_gnt;
    logic              xfer;
    logic [IDX_W-1:0]  sel_index;
    logic [DATA_W-1:0] sel_data;
    logic              w_en_reg;
    logic [IDX_W-1:0]  w_index_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic [NREG-1:0]   pending_reg;

    // ALU jumps to the front once it has been refused STARVE_LIMIT times in a row.
    assign promote = (starve_reg == LIMIT_C);

    // Fixed-priority grant; ready only ever asserts alongside the matching valid.
    always_comb begin
        ld_gnt = 1'b0;
        dv_gnt = 1'b0;
        al_gnt = 1'b0;
        if (promote && al_valid) begin
            al_gnt = 1'b1;
        end else if (ld_valid) begin
            ld_gnt = 1'b1;
        end else if (dv_valid) begin
            dv_gnt = 1'b1;
        end else if (al_valid) begin
            al_gnt = 1'b1;
        end
    end

    assign ld_ready = ld_gnt;
    assign dv_ready = dv_gnt;
    assign al_ready = al_gnt;
    assign xfer     = ld_gnt | dv_gnt | al_gnt;

    // Route the granted source's index and data towards the output register.
    always_comb begin
        sel_index = ld_index;
        sel_data  = ld_data;
        if (dv_gnt) begin
            sel_index = dv_index;
            sel_data  = dv_data;
        end else if (al_gnt) begin
            sel_index = al_index;
            sel_data  = al_data;
        end
    end

    // Count consecutive refused ALU cycles, saturating; any idle or granted cycle clears it.
    always_comb begin
        starve_next = starve_reg;
        if (!al_valid || al_gnt) begin
            starve_next = '0;
        end else if (starve_reg != LIMIT_C) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // Starvation counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

    // One-cycle write register; writes to f0 are dropped by never raising w_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en_reg    <= 1'b0;
            w_index_reg <= '0;
            w_data_reg  <= '0;
        end else if (xfer) begin
            w_en_reg    <= (sel_index != '0);
            w_index_reg <= sel_index;
            w_data_reg  <= sel_data;
        end else begin
            w_en_reg    <= 1'b0;
        end
    end

    assign w_en    = w_en_reg;
    assign w_index = w_index_reg;
    assign w_data  = w_data_reg;

    // One scoreboard bit per register. A new issue beats the commit of an older
    // write to the same register, so the set has priority over the clear.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
            logic set_hit;
            logic clr_hit;
            assign set_hit = iss_en && (iss_index == IDX_W'(gi)) && (gi != 0);
            assign clr_hit = w_en_reg && (w_index_reg == IDX_W'(gi));

            // Scoreboard bit update.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pending_reg[gi] <= 1'b0;
                end else if (set_hit) begin
                    pending_reg[gi] <= 1'b1;
                end else if (clr_hit) begin
                    pending_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // No bypass: readers stall until the commit edge has cleared the bit.
    assign hazard = pending_reg[chk_rs1] | pending_reg[chk_rs2] | pending_reg[chk_rd];

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: grant table, directed corner sequences and a random
// run, all compared every cycle against a behavioural model of the writeback stage.
module tb_fp_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        ld_valid, dv_valid, al_valid;
    logic        ld_ready, dv_ready, al_ready;
    logic [4:0]  ld_index, dv_index, al_index;
    logic [31:0] ld_data, dv_data, al_data;
    logic        iss_en;
    logic [4:0]  iss_index, chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic        w_en;
    logic [4:0]  w_index;
    logic [31:0] w_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: which registers await a result, how long the ALU has waited,
    // and what the write port should show this cycle.
    bit          m_pend[32];
    int          m_starve;
    bit          m_wen;
    logic [4:0]  m_widx;
    logic [31:0] m_wdata;

    fp_wb_arbiter #(.DATA_W(32), .IDX_W(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_index(ld_index), .ld_data(ld_data),
        .dv_valid(dv_valid), .dv_ready(dv_ready), .dv_index(dv_index), .dv_data(dv_data),
        .al_valid(al_valid), .al_ready(al_ready), .al_index(al_index), .al_data(al_data),
        .iss_en(iss_en), .iss_index(iss_index),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .w_en(w_en), .w_index(w_index), .w_data(w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_starve = 0;
        m_wen    = 1'b0;
        m_widx   = '0;
        m_wdata  = '0;
    endtask

    // Source number (1=load, 2=div, 3=alu, 0=none) taken from a priority list.
    function automatic int model_grant();
        int order[3];
        bit v[4];
        v[0] = 1'b0; v[1] = ld_valid; v[2] = dv_valid; v[3] = al_valid;
        if (m_starve >= LIMIT) begin order[0] = 3; order[1] = 1; order[2] = 2; end
        else                   begin order[0] = 1; order[1] = 2; order[2] = 3; end
        for (int k = 0; k < 3; k++) if (v[order[k]]) return order[k];
        return 0;
    endfunction

    function automatic bit model_hazard();
        return m_pend[chk_rs1] | m_pend[chk_rs2] | m_pend[chk_rd];
    endfunction

    task automatic model_update(input int g);
        logic [4:0]  idx;
        logic [31:0] dat;
        if (m_wen) m_pend[m_widx] = 1'b0;
        if (iss_en && iss_index != 0) m_pend[iss_index] = 1'b1;
        if (!al_valid || g == 3) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        idx = (g == 1) ? ld_index : (g == 2) ? dv_index : al_index;
        dat = (g == 1) ? ld_data  : (g == 2) ? dv_data  : al_data;
        if (g != 0) begin
            m_wen   = (idx != 0);
            m_widx  = idx;
            m_wdata = dat;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    // One cycle: compare everything against the model, then clock and advance the model.
    task automatic step(input string tag);
        int g;
        g = model_grant();
        #1;
        check({tag, " ld_ready"}, 32'(ld_ready), 32'(g == 1));
        check({tag, " dv_ready"}, 32'(dv_ready), 32'(g == 2));
        check({tag, " al_ready"}, 32'(al_ready), 32'(g == 3));
        check({tag, " w_en"},     32'(w_en),     32'(m_wen));
        check({tag, " w_index"},  32'(w_index),  32'(m_widx));
        check({tag, " w_data"},   w_data,        m_wdata);
        check({tag, " hazard"},   32'(hazard),   32'(model_hazard()));
        $display("%s: v=%b%b%b rdy=%b%b%b w_en=%b w_index=%0d w_data=%h hazard=%b",
                 tag, ld_valid, dv_valid, al_valid, ld_ready, dv_ready, al_ready,
                 w_en, w_index, w_data, hazard);
        @(posedge clk);
        model_update(g);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ld_valid = 0; dv_valid = 0; al_valid = 0; iss_en = 0;
    endtask

    typedef struct {
        logic ld_v, dv_v, al_v;
        logic exp_ld, exp_dv, exp_al;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 1, 1, 1, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 1, 0};
        tbl[2] = '{0, 0, 1, 0, 0, 1};
        tbl[3] = '{1, 0, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 0, 1, 0, 0};
        tbl[6] = '{0, 1, 0, 0, 1, 0};
        tbl[7] = '{0, 1, 1, 0, 1, 0};

        rst = 0;
        idle_inputs();
        ld_index = 0; dv_index = 0; al_index = 0;
        ld_data = 0; dv_data = 0; al_data = 0;
        iss_index = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset w_en", 32'(w_en), 32'h0);
        check("reset w_index", 32'(w_index), 32'h0);
        check("reset w_data", w_data, 32'h0);
        check("reset hazard", 32'(hazard), 32'h0);
        @(negedge clk);
        rst = 1;

        // Grant table (never more than two refused ALU cycles, so no promotion).
        ld_index = 1; dv_index = 2; al_index = 3;
        ld_data = 32'h11; dv_data = 32'h22; al_data = 32'h33;
        for (int i = 0; i < 8; i++) begin
            ld_valid = tbl[i].ld_v; dv_valid = tbl[i].dv_v; al_valid = tbl[i].al_v;
            #1;
            check($sformatf("tbl%0d ld_ready", i), 32'(ld_ready), 32'(tbl[i].exp_ld));
            check($sformatf("tbl%0d dv_ready", i), 32'(dv_ready), 32'(tbl[i].exp_dv));
            check($sformatf("tbl%0d al_ready", i), 32'(al_ready), 32'(tbl[i].exp_al));
            step($sformatf("tbl%0d", i));
        end
        idle_inputs();
        step("drain");

        // Single ALU result to a pending register.
        iss_en = 1; iss_index = 3;
        step("alu issue");
        iss_en = 0; al_valid = 1; al_index = 3; al_data = 32'h3F800000; chk_rs1 = 3;
        #1;
        check("alu same-cycle ready", 32'(al_ready), 32'h1);
        step("alu xfer");
        al_valid = 0;
        #1;
        check("alu w_en", 32'(w_en), 32'h1);
        check("alu w_index", 32'(w_index), 32'd3);
        check("alu w_data", w_data, 32'h3F800000);
        check("alu hazard during write", 32'(hazard), 32'h1);
        step("alu write");
        #1;
        check("alu hazard after commit", 32'(hazard), 32'h0);
        step("alu after");
        chk_rs1 = 0;

        // All three valid and held until accepted.
        ld_valid = 1; dv_valid = 1; al_valid = 1;
        ld_index = 5; dv_index = 6; al_index = 7;
        ld_data = 32'h55; dv_data = 32'h66; al_data = 32'h77;
        #1; check("all3 first ld", 32'(ld_ready), 32'h1);
        step("all3 a");
        ld_valid = 0;
        #1; check("all3 second dv", 32'(dv_ready), 32'h1);
        check("all3 w_index 5", 32'(w_index), 32'd5);
        step("all3 b");
        dv_valid = 0;
        #1; check("all3 third al", 32'(al_ready), 32'h1);
        check("all3 w_index 6", 32'(w_index), 32'd6);
        step("all3 c");
        al_valid = 0;
        #1; check("all3 w_index 7", 32'(w_index), 32'd7);
        check("all3 w_en", 32'(w_en), 32'h1);
        step("all3 d");

        // Load stream starving the ALU.
        ld_valid = 1; al_valid = 1; ld_index = 10; al_index = 11;
        for (int i = 0; i < LIMIT; i++) begin
            #1; check($sformatf("starve deny%0d", i), 32'(al_ready), 32'h0);
            step($sformatf("starve%0d", i));
        end
        #1;
        check("starve promoted al", 32'(al_ready), 32'h1);
        check("starve promoted ld off", 32'(ld_ready), 32'h0);
        step("starve grant");
        al_valid = 0;
        #1; check("starve load resumes", 32'(ld_ready), 32'h1);
        step("starve resume");
        idle_inputs();
        step("starve drain");

        // Issue and commit to the same register on the same edge.
        iss_en = 1; iss_index = 9;
        step("waw issue");
        iss_en = 0; ld_valid = 1; ld_index = 9; ld_data = 32'h99;
        step("waw xfer");
        ld_valid = 0; iss_en = 1; iss_index = 9; chk_rd = 9;
        #1; check("waw w_en", 32'(w_en), 32'h1);
        step("waw collide");
        iss_en = 0;
        #1; check("waw hazard kept", 32'(hazard), 32'h1);
        step("waw after");
        chk_rd = 0;

        // Transfer to f0.
        ld_valid = 1; ld_index = 0; ld_data = 32'hDEADBEEF;
        #1; check("f0 ready", 32'(ld_ready), 32'h1);
        step("f0 xfer");
        ld_valid = 0;
        #1; check("f0 w_en", 32'(w_en), 32'h0);
        check("f0 hazard", 32'(hazard), 32'h0);
        step("f0 after");

        // Asynchronous reset while a write is being presented.
        iss_en = 1; iss_index = 4;
        step("rst issue");
        iss_en = 0; ld_valid = 1; ld_index = 4; ld_data = 32'h44; chk_rs1 = 4;
        step("rst xfer");
        ld_valid = 0;
        #1;
        check("rst pre w_en", 32'(w_en), 32'h1);
        check("rst pre hazard", 32'(hazard), 32'h1);
        #2 rst = 0;
        #1;
        check("rst w_en", 32'(w_en), 32'h0);
        check("rst w_index", 32'(w_index), 32'h0);
        check("rst w_data", w_data, 32'h0);
        check("rst hazard", 32'(hazard), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1;
        step("rst release");
        chk_rs1 = 0;

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ld_valid  = ($urandom_range(0, 9) < 7);
            dv_valid  = ($urandom_range(0, 9) < 4);
            al_valid  = ($urandom_range(0, 9) < 6);
            ld_index  = 5'($urandom_range(0, 7));
            dv_index  = 5'($urandom_range(0, 7));
            al_index  = 5'($urandom_range(0, 7));
            ld_data   = $urandom;
            dv_data   = $urandom;
            al_data   = $urandom;
            iss_en    = ($urandom_range(0, 9) < 5);
            iss_index = 5'($urandom_range(0, 7));
            chk_rs1   = 5'($urandom_range(0, 7));
            chk_rs2   = 5'($urandom_range(0, 7));
            chk_rd    = 5'($urandom_range(0, 7));
            step($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
